// File: rtl/ru_write_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ru_write_ctrl_pkg
// Shared definitions for the RU write-sequencing stage. It holds the
// sequencer state encoding, the datapath geometry constants and the
// derived SRAM write-data width.
// No ports (package).
// ----------------------------------------------------------------------------
package ru_write_ctrl_pkg;

    localparam int unsigned CH_NUM       = 24;  // channels per SRAM address (<= 128)
    localparam int unsigned ACT_PER_ADDR = 4;   // activations per channel per address
    localparam int unsigned BW_PER_ACT   = 16;  // bits per activation
    localparam int unsigned PIPE_DLY     = 5;   // accepted beat -> SRAM write (>= 1)
    localparam int unsigned FMAP_IDX_W   = 7;

    localparam int unsigned LANES   = CH_NUM * ACT_PER_ADDR;
    localparam int unsigned WDATA_W = LANES * BW_PER_ACT;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } wr_state_e;

endpackage

// File: rtl/ru_write_ctrl_if.sv
// ----------------------------------------------------------------------------
// ru_write_ctrl_if
// Bundles the result-beat input side and the SRAM / bytemask-decoder output
// side of ru_write_ctrl.
//   start, in_valid, in_data            : upstream conv datapath -> sequencer
//   busy, done                          : sequencer status
//   fmap_idx_delay5                     : channel index at the write stage
//   sram_wen (active-low), sram_waddr,
//   sram_wdata                          : SRAM write port
// Modports: slave = sequencer view, master = upstream/environment view.
// ----------------------------------------------------------------------------
interface ru_write_ctrl_if #(
    parameter int unsigned ADDR_W = 10
);

    logic                                       start;
    logic                                       in_valid;
    logic [ru_write_ctrl_pkg::BW_PER_ACT-1:0]   in_data;
    logic                                       busy;
    logic [ru_write_ctrl_pkg::FMAP_IDX_W-1:0]   fmap_idx_delay5;
    logic                                       sram_wen;
    logic [ADDR_W-1:0]                          sram_waddr;
    logic [ru_write_ctrl_pkg::WDATA_W-1:0]      sram_wdata;
    logic                                       done;

    modport slave (
        input  start, in_valid, in_data,
        output busy, fmap_idx_delay5, sram_wen, sram_waddr, sram_wdata, done
    );

    modport master (
        output start, in_valid, in_data,
        input  busy, fmap_idx_delay5, sram_wen, sram_waddr, sram_wdata, done
    );

endinterface

// File: rtl/ru_dly_line.sv
// ----------------------------------------------------------------------------
// ru_dly_line
// Generic DEPTH-stage shift register with asynchronous active-low clear.
// DEPTH = 0 degenerates to a wire.
//   clk   : clock, rising edge
//   srstn : asynchronous clear, active-low (all stages -> 0)
//   d     : WIDTH-bit input
//   q     : WIDTH-bit output, d delayed by DEPTH cycles
// ----------------------------------------------------------------------------
module ru_dly_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             srstn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign q = d;
        end else begin : g_sr
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge clk or negedge srstn) begin
                if (!srstn) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        stage[i] <= '0;
                    end
                end else begin
                    stage[0] <= d;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/ru_write_ctrl.sv
// ----------------------------------------------------------------------------
// ru_write_ctrl
// Write-sequencing stage in front of the RU bytemask decoder. Per start
// pulse it accepts NUM_ADDR * CH_NUM result beats, tags each with its
// channel index and SRAM address, delays it PIPE_DLY cycles and issues one
// SRAM write per beat, then pulses done once the pipeline has drained.
//   clk   : clock, rising edge
//   srstn : asynchronous reset, active-low
//   bus   : ru_write_ctrl_if.slave
//           in : start, in_valid, in_data
//           out: busy, fmap_idx_delay5, sram_wen (active-low), sram_waddr,
//                sram_wdata (in_data replicated to every lane), done
// ----------------------------------------------------------------------------
module ru_write_ctrl
    import ru_write_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned NUM_ADDR = 256
) (
    input  logic               clk,
    input  logic               srstn,
    ru_write_ctrl_if.slave     bus
);

    localparam int unsigned DRAIN_W = (PIPE_DLY > 1) ? $clog2(PIPE_DLY) : 1;
    localparam int unsigned PKT_W   = 1 + FMAP_IDX_W + ADDR_W + BW_PER_ACT;

    wr_state_e              state;
    logic [FMAP_IDX_W-1:0]  idx_cnt;
    logic [ADDR_W-1:0]      addr_cnt;
    logic [DRAIN_W-1:0]     drain_cnt;
    logic                   busy_q;
    logic                   done_q;

    logic                   accept;
    logic                   last_idx;
    logic                   last_addr;

    assign accept    = (state == RUN) && bus.in_valid;
    assign last_idx  = (idx_cnt == FMAP_IDX_W'(CH_NUM - 1));
    assign last_addr = (addr_cnt == ADDR_W'(NUM_ADDR - 1));

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            state     <= IDLE;
            idx_cnt   <= '0;
            addr_cnt  <= '0;
            drain_cnt <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= RUN;
                        idx_cnt  <= '0;
                        addr_cnt <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.in_valid) begin
                        if (last_idx) begin
                            idx_cnt <= '0;
                            if (last_addr) begin
                                addr_cnt  <= '0;
                                drain_cnt <= '0;
                                state     <= FLUSH;
                            end else begin
                                addr_cnt <= addr_cnt + 1'b1;
                            end
                        end else begin
                            idx_cnt <= idx_cnt + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    // PIPE_DLY drain cycles: the last write lands in the final
                    // FLUSH cycle, so done follows it by exactly one cycle.
                    if (drain_cnt == DRAIN_W'(PIPE_DLY - 1)) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // The output registers form the last delay stage, so the shift register
    // itself is one stage shorter than PIPE_DLY.
    logic [PKT_W-1:0]       pkt_in;
    logic [PKT_W-1:0]       pkt_out;
    logic                   pkt_v;
    logic [FMAP_IDX_W-1:0]  pkt_idx;
    logic [ADDR_W-1:0]      pkt_addr;
    logic [BW_PER_ACT-1:0]  pkt_data;

    assign pkt_in = {accept, idx_cnt, addr_cnt, bus.in_data};
    assign {pkt_v, pkt_idx, pkt_addr, pkt_data} = pkt_out;

    ru_dly_line #(
        .WIDTH (PKT_W),
        .DEPTH (PIPE_DLY - 1)
    ) u_dly (
        .clk   (clk),
        .srstn (srstn),
        .d     (pkt_in),
        .q     (pkt_out)
    );

    logic                   wen_q;
    logic [FMAP_IDX_W-1:0]  fidx_q;
    logic [ADDR_W-1:0]      waddr_q;
    logic [BW_PER_ACT-1:0]  wdata_q;

    // Bubbles deassert the write and zero the index; address/data hold.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            wen_q   <= 1'b1;
            fidx_q  <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else if (pkt_v) begin
            wen_q   <= 1'b0;
            fidx_q  <= pkt_idx;
            waddr_q <= pkt_addr;
            wdata_q <= pkt_data;
        end else begin
            wen_q  <= 1'b1;
            fidx_q <= '0;
        end
    end

    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.sram_wen        = wen_q;
    assign bus.fmap_idx_delay5 = fidx_q;
    assign bus.sram_waddr      = waddr_q;
    assign bus.sram_wdata      = {LANES{wdata_q}};

endmodule

// File: tb/tb_ru_write_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ru_write_ctrl
// Two sequencers share one stimulus stream: dut_a writes a single address
// per layer, dut_b four addresses. Expected outputs come from a per-cycle
// schedule: each accepted beat n books a write at (cycle + PIPE_DLY) with
// channel n % CH_NUM and address n / CH_NUM.
// ----------------------------------------------------------------------------
module tb_ru_write_ctrl;

    localparam int PD    = ru_write_ctrl_pkg::PIPE_DLY;
    localparam int CH    = ru_write_ctrl_pkg::CH_NUM;
    localparam int BW    = ru_write_ctrl_pkg::BW_PER_ACT;
    localparam int LANES = ru_write_ctrl_pkg::LANES;
    localparam int WD_W  = ru_write_ctrl_pkg::WDATA_W;
    localparam int AW    = 10;
    localparam int NCYC  = 2048;
    localparam int NEVER = 1 << 30;

    logic          clk = 1'b0;
    logic          srstn = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [BW-1:0] in_data = '0;

    always #5 clk = ~clk;

    ru_write_ctrl_if #(.ADDR_W(AW)) bus_a ();
    ru_write_ctrl_if #(.ADDR_W(AW)) bus_b ();

    assign bus_a.start    = start;
    assign bus_a.in_valid = in_valid;
    assign bus_a.in_data  = in_data;
    assign bus_b.start    = start;
    assign bus_b.in_valid = in_valid;
    assign bus_b.in_data  = in_data;

    ru_write_ctrl #(.ADDR_W(AW), .NUM_ADDR(1)) dut_a (
        .clk   (clk),
        .srstn (srstn),
        .bus   (bus_a.slave)
    );

    ru_write_ctrl #(.ADDR_W(AW), .NUM_ADDR(4)) dut_b (
        .clk   (clk),
        .srstn (srstn),
        .bus   (bus_b.slave)
    );

    // reference schedule
    logic          exp_v [2][NCYC];
    logic [6:0]    exp_i [2][NCYC];
    logic [AW-1:0] exp_a [2][NCYC];
    logic [BW-1:0] exp_d [2][NCYC];
    int            start_cyc [2];
    int            done_cyc  [2];
    int            beats     [2];
    int            total     [2];
    logic [AW-1:0] last_a    [2];
    logic [BW-1:0] last_d    [2];

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s dut%0d cyc%0d: got %0h expected %0h", tag, d, cyc, obs, expv);
        end
    endtask

    task automatic chk_wd(input int d, input logic [WD_W-1:0] obs, input logic [WD_W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL wdata dut%0d cyc%0d: got low %0h expected low %0h", d, cyc, obs[31:0], expv[31:0]);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            start_cyc[d] = -1;
            done_cyc[d]  = -1;
            beats[d]     = 0;
            last_a[d]    = '0;
            last_d[d]    = '0;
            for (int t = 0; t < NCYC; t++) exp_v[d][t] = 1'b0;
        end
    endtask

    task automatic check_dut(input int d, input logic busy, input logic [6:0] idx, input logic wen,
                             input logic [AW-1:0] waddr, input logic [WD_W-1:0] wdata, input logic done);
        logic          hit;
        logic [6:0]    e_i;
        logic [AW-1:0] e_a;
        logic [BW-1:0] e_d;
        logic [WD_W-1:0] e_wd;
        hit = (cyc < NCYC) && exp_v[d][cyc];
        e_i = hit ? exp_i[d][cyc] : 7'd0;
        e_a = hit ? exp_a[d][cyc] : last_a[d];
        e_d = hit ? exp_d[d][cyc] : last_d[d];
        e_wd = {LANES{e_d}};
        chk("busy",  d, 32'(busy), 32'((cyc > start_cyc[d]) && (cyc <= done_cyc[d])));
        chk("done",  d, 32'(done), 32'(cyc == done_cyc[d]));
        chk("wen",   d, 32'(wen),  32'(!hit));
        chk("fidx",  d, 32'(idx),  32'(e_i));
        chk("waddr", d, 32'(waddr), 32'(e_a));
        chk_wd(d, wdata, e_wd);
        last_a[d] = e_a;
        last_d[d] = e_d;
    endtask

    task automatic model_step(input int d);
        logic live;
        live = (cyc > start_cyc[d]) && (cyc <= done_cyc[d]);
        if (start && !live) begin
            start_cyc[d] = cyc;
            done_cyc[d]  = NEVER;
            beats[d]     = 0;
        end else if (live && in_valid && beats[d] < total[d]) begin
            if (cyc + PD < NCYC) begin
                exp_v[d][cyc+PD] = 1'b1;
                exp_i[d][cyc+PD] = 7'(beats[d] % CH);
                exp_a[d][cyc+PD] = AW'(beats[d] / CH);
                exp_d[d][cyc+PD] = in_data;
            end
            beats[d]++;
            if (beats[d] == total[d]) done_cyc[d] = cyc + PD + 1;
        end
    endtask

    // one clock cycle: check outputs mid-cycle, advance the model, cross the edge
    task automatic step();
        @(negedge clk);
        if (!srstn) model_reset();
        check_dut(0, bus_a.busy, bus_a.fmap_idx_delay5, bus_a.sram_wen, bus_a.sram_waddr,
                  bus_a.sram_wdata, bus_a.done);
        check_dut(1, bus_b.busy, bus_b.fmap_idx_delay5, bus_b.sram_wen, bus_b.sram_waddr,
                  bus_b.sram_wdata, bus_b.done);
        if (srstn) begin
            model_step(0);
            model_step(1);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    initial begin
        total[0] = CH * 1;
        total[1] = CH * 4;
        model_reset();

        // reset
        repeat (3) step();
        srstn = 1'b1;

        // idle: beats without start are ignored
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = BW'($urandom);
            step();
        end
        in_valid = 1'b0;

        // layer start, 24 back-to-back beats 1..24; stray start in RUN
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            in_valid = 1'b1;
            in_data  = BW'(i);
            start    = (i == 10);
            step();
        end
        start = 1'b0;

        // dut_b continues (index wrap to address 1); dut_a flushes, stray starts in FLUSH/DONE
        for (int j = 0; j < 24; j++) begin
            in_valid = 1'b1;
            in_data  = BW'($urandom);
            start    = (j == 2) || (j == 5);
            step();
        end
        start = 1'b0;

        // remaining dut_b beats with 2-cycle bubbles
        for (int k = 0; k < 48; k++) begin
            in_valid = 1'b1;
            in_data  = BW'($urandom);
            step();
            in_valid = 1'b0;
            repeat (2) step();
        end
        repeat (10) step();

        // async reset while write 10 of a new layer is on the outputs
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            in_valid = 1'b1;
            in_data  = BW'($urandom);
            step();
        end
        srstn = 1'b0;
        #1;
        chk("rst_wen",  0, 32'(bus_a.sram_wen), 32'd1);
        chk("rst_fidx", 0, 32'(bus_a.fmap_idx_delay5), 32'd0);
        chk("rst_busy", 1, 32'(bus_b.busy), 32'd0);
        chk("rst_wen",  1, 32'(bus_b.sram_wen), 32'd1);
        step();
        in_valid = 1'b0;
        step();
        srstn = 1'b1;
        repeat (8) step();

        // fresh layer with random valid pattern, starts again from idx 0 / address 0
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 80; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = BW'($urandom);
            step();
        end
        in_valid = 1'b0;
        repeat (12) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ru_write_ctrl.md
Name: ru_write_ctrl

Overview:
Write-sequencing stage directly upstream of the RU bytemask decoder. Accepts one post-activation result per cycle from the conv datapath, tracks its channel index (0..CH_NUM-1) and SRAM address, and delays them through a PIPE_DLY-stage line. It drives the decoder's fmap_idx_delay5 input plus the SRAM write-enable, address and lane-replicated write data. It sequences one layer of NUM_ADDR addresses per start pulse.

Parameters:
CH_NUM, 24, channels per SRAM address (must be ≤ 128; fmap index is 7 bits)
ACT_PER_ADDR, 4, activations per channel per address
BW_PER_ACT, 16, bits per activation
PIPE_DLY, 5, delay from accepted beat to SRAM write (≥ 1)
ADDR_W, 10, SRAM address width
NUM_ADDR, 256, addresses written per layer (≤ 2^ADDR_W)

Ports:
clk  in  1  clock, rising edge
srstn  in  1  reset, asynchronous, active-low
start  in  1  one-cycle layer start pulse
in_valid  in  1  result beat valid
in_data  in  BW_PER_ACT  result activation
busy  out  1  high whenever state != IDLE
fmap_idx_delay5  out  7  channel index of the beat at the write stage (to the bytemask decoder)
sram_wen  out  1  SRAM write enable, active-low
sram_waddr  out  ADDR_W  SRAM write address
sram_wdata  out  CH_NUM*ACT_PER_ADDR*BW_PER_ACT  in_data replicated to every lane
done  out  1  one-cycle layer-complete pulse

Behaviour:
- Reset values: busy 0, fmap_idx_delay5 0, sram_wen 1, sram_waddr 0, sram_wdata 0, done 0. Reset also clears state, counters and every delay-line stage.
- Reset asserted mid-layer: all pending writes are dropped. Nothing is written after reset.
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE: start moves to RUN and clears idx_cnt and addr_cnt. in_valid is ignored.
  - RUN: each in_valid beat is accepted. The beat carries (idx_cnt, addr_cnt, in_data) into the delay line.
  - RUN, after an accepted beat: idx_cnt increments. At CH_NUM-1 it wraps to 0 and addr_cnt increments.
  - RUN, final beat (idx_cnt == CH_NUM-1 and addr_cnt == NUM_ADDR-1): moves to FLUSH. addr_cnt wraps to 0.
  - FLUSH: in_valid is ignored. A drain counter runs for PIPE_DLY cycles, then the FSM moves to DONE.
  - DONE: done = 1 for exactly one cycle, then the FSM returns to IDLE.
- start in any state other than IDLE is ignored.
- Latency: in_valid high in cycle c gives sram_wen = 0 in cycle c+PIPE_DLY. In that same cycle fmap_idx_delay5, sram_waddr and sram_wdata carry that beat's values. All outputs are registered.
- Completion timing: the last beat in cycle c gives its write in c+PIPE_DLY and done in cycle c+PIPE_DLY+1.
- Bubbles (no valid beat at the output stage): sram_wen = 1, fmap_idx_delay5 = 0. sram_waddr and sram_wdata hold their previous values.
- Back-to-back beats: full throughput, one write per cycle, no stalls. There is no backpressure; upstream must not present beats outside RUN.
- sram_wdata: in_data is copied into all CH_NUM*ACT_PER_ADDR lanes. The downstream bytemask selects the lane that is written.
- Widths: idx_cnt is zero-extended to 7 bits. addr_cnt is ADDR_W bits.

Decomposition:
- Shared package holds:
  - state enum (IDLE/RUN/FLUSH/DONE);
  - constants CH_NUM, ACT_PER_ADDR, BW_PER_ACT, PIPE_DLY;
  - FMAP_IDX_W = 7.
- One sub-module: ru_dly_line, a generic shift register.
  - Parameterised by WIDTH and DEPTH, with async active-low clear.
  - Instantiated once carrying {valid, idx, addr, data}.

Test Plan:
- Reset then idle: hold in_valid = 1 with no start → sram_wen stays 1, busy = 0, done never pulses.
- Single address: NUM_ADDR = 1, start, 24 consecutive beats with data 0x0001..0x0018 → writes in cycles c0+5..c0+28, fmap_idx_delay5 = 0..23, sram_waddr = 0, done in cycle c0+29.
- Index wrap and address increment: 48 beats with NUM_ADDR = 4 → beat 24 writes idx 0 at address 1. The FSM stays in RUN.
- Bubbles: beats with in_valid gaps of 2 cycles → sram_wen pattern mirrors in_valid delayed by 5, and fmap_idx_delay5 = 0 in bubble cycles.
- Async reset at write 10 of a layer → all outputs are at reset values immediately and no further sram_wen = 0 occurs. A new start then writes from idx 0, address 0.
- start pulses during RUN and FLUSH → ignored: counters are unaffected and exactly one done pulse occurs.
